// File: rtl/mem_writeback.sv
// Memory/writeback stage: data-memory load/store over req/ack, load alignment, RF write.
// Optional misaligned-access trap: define MEM_WB_MISALIGN_CHK_EN.
module mem_writeback (
    input  logic        clk,
    input  logic        resetb,
    input  logic [31:0] wb_result,
    input  logic        wb_memwr,
    input  logic        wb_mem2reg,
    input  logic        wb_alu2reg,
    input  logic [4:0]  wb_dst_sel,
    input  logic [2:0]  wb_aluop,
    input  logic [31:0] wb_maddr,
    input  logic [1:0]  wb_raddr,
    input  logic [31:0] wb_waddr,
    input  logic [3:0]  wb_wstrb,
    input  logic [31:0] wb_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_stall,
    output logic        wb_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;
    logic        ld_q, ld_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  lane_q, lane_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        err_q, err_d;
    logic        misal;
    logic [31:0] ld_data;
    logic        busy;

    // Word address only; byte lanes come from wb_raddr / strobes
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wb_maddr[1:0], wb_waddr[1:0]};

`ifdef MEM_WB_MISALIGN_CHK_EN
    always_comb begin
        misal = 1'b0;
        if (wb_memwr) begin
            misal = (wb_aluop == 3'd1 && wb_waddr[0]) ||
                    (wb_aluop == 3'd2 && wb_waddr[1:0] != 2'b00);
        end else if (wb_mem2reg) begin
            misal = ((wb_aluop == 3'd1 || wb_aluop == 3'd5) && wb_raddr[0]) ||
                    (wb_aluop == 3'd2 && wb_raddr != 2'b00);
        end
    end
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = dmem_rdata[8*lane_q +: 8];
        h = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            3'd0:    ld_data = {{24{b[7]}}, b};
            3'd1:    ld_data = {{16{h[15]}}, h};
            3'd2:    ld_data = dmem_rdata;
            3'd4:    ld_data = {24'b0, b};
            3'd5:    ld_data = {16'b0, h};
            default: ld_data = 32'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rd_d       = rd_q;
        lane_d     = lane_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (misal) begin
                    err_d = 1'b1;
                end else if (wb_memwr) begin
                    ld_d    = 1'b0;
                    addr_d  = wb_waddr[31:2];
                    strb_d  = wb_wstrb;
                    wdata_d = wb_wdata;
                    state_d = BUSY;
                end else if (wb_mem2reg) begin
                    ld_d    = 1'b1;
                    addr_d  = wb_maddr[31:2];
                    strb_d  = 4'b0;
                    lane_d  = wb_raddr;
                    op_d    = wb_aluop;
                    rd_d    = wb_dst_sel;
                    state_d = BUSY;
                end else if (wb_alu2reg) begin
                    rf_we_d    = |wb_dst_sel;
                    rf_waddr_d = wb_dst_sel;
                    rf_wdata_d = wb_result;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (ld_q) begin
                        rf_we_d    = |rd_q;
                        rf_waddr_d = rd_q;
                        rf_wdata_d = ld_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= IDLE;
            ld_q       <= 1'b0;
            addr_q     <= 30'b0;
            strb_q     <= 4'b0;
            wdata_q    <= 32'b0;
            op_q       <= 3'b0;
            rd_q       <= 5'b0;
            lane_q     <= 2'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'b0;
            rf_wdata_q <= 32'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            lane_q     <= lane_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign busy       = (state_q == BUSY);
    assign dmem_req   = busy;
    assign dmem_we    = busy & ~ld_q;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_wstrb = busy ? strb_q : 4'b0;
    assign dmem_wdata = wdata_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign wb_stall   = busy;
    assign wb_err     = err_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed vector table, hand sequences, randomized ops.
// Misalign checks compiled in when MEM_WB_MISALIGN_CHK_EN is defined.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        resetb;
    logic [31:0] wb_result;
    logic        wb_memwr, wb_mem2reg, wb_alu2reg;
    logic [4:0]  wb_dst_sel;
    logic [2:0]  wb_aluop;
    logic [31:0] wb_maddr;
    logic [1:0]  wb_raddr;
    logic [31:0] wb_waddr;
    logic [3:0]  wb_wstrb;
    logic [31:0] wb_wdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall, wb_err;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_writeback dut (
        .clk(clk), .resetb(resetb), .wb_result(wb_result),
        .wb_memwr(wb_memwr), .wb_mem2reg(wb_mem2reg), .wb_alu2reg(wb_alu2reg),
        .wb_dst_sel(wb_dst_sel), .wb_aluop(wb_aluop), .wb_maddr(wb_maddr),
        .wb_raddr(wb_raddr), .wb_waddr(wb_waddr), .wb_wstrb(wb_wstrb),
        .wb_wdata(wb_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
        .wb_err(wb_err)
    );

    typedef struct {
        string       name;
        bit          st;
        logic [2:0]  op;
        logic [4:0]  dst;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] rdat;
        int          waits;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic clear_in();
        wb_memwr   = 1'b0;
        wb_mem2reg = 1'b0;
        wb_alu2reg = 1'b0;
        wb_result  = $urandom;
        wb_dst_sel = 5'($urandom);
        wb_aluop   = 3'($urandom);
        wb_maddr   = $urandom;
        wb_raddr   = wb_maddr[1:0];
        wb_waddr   = $urandom;
        wb_wstrb   = 4'($urandom);
        wb_wdata   = $urandom;
    endtask

    // Reference load result from the ISA definition of each funct3
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd0: return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd2: return rd;
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_alu(input logic [4:0] dst, input logic [31:0] res);
        @(negedge clk);
        clear_in();
        wb_alu2reg = 1'b1;
        wb_dst_sel = dst;
        wb_result  = res;
        @(negedge clk);
        clear_in();
        chk("alu_rf_we", 32'(rf_we), 32'(dst != 5'd0));
        if (dst != 5'd0) begin
            chk("alu_rf_waddr", 32'(rf_waddr), 32'(dst));
            chk("alu_rf_wdata", rf_wdata, res);
        end
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_stall", 32'(wb_stall), 32'd0);
    endtask

    task automatic run_mem(input vec_t v);
        int stalls;
        logic [31:0] wa;
        stalls = 0;
        wa = {v.addr[31:2], 2'b00};
        @(negedge clk);
        clear_in();
        wb_aluop = v.op;
        if (v.st) begin
            wb_memwr = 1'b1;
            wb_waddr = v.addr;
            wb_wstrb = v.strb;
            wb_wdata = v.wd;
        end else begin
            wb_mem2reg = 1'b1;
            wb_alu2reg = 1'b1;
            wb_maddr   = v.addr;
            wb_raddr   = v.addr[1:0];
            wb_dst_sel = v.dst;
        end
        @(negedge clk);
        clear_in();
        chk({v.name, "_req"}, 32'(dmem_req), 32'd1);
        chk({v.name, "_we"}, 32'(dmem_we), 32'(v.st));
        chk({v.name, "_addr"}, dmem_addr, wa);
        chk({v.name, "_wstrb"}, 32'(dmem_wstrb), v.st ? 32'(v.strb) : 32'd0);
        if (v.st) chk({v.name, "_wdata"}, dmem_wdata, v.wd);
        for (int i = 0; i <= v.waits; i++) begin
            if (wb_stall) stalls++;
            if (i == v.waits) begin
                chk({v.name, "_req_held"}, 32'(dmem_req), 32'd1);
                chk({v.name, "_addr_held"}, dmem_addr, wa);
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdat;
            end else begin
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            clear_in();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        chk({v.name, "_rf_we"}, 32'(rf_we), 32'(v.exp_we));
        if (v.exp_we) begin
            chk({v.name, "_rf_waddr"}, 32'(rf_waddr), 32'(v.dst));
            chk({v.name, "_rf_wdata"}, rf_wdata, v.exp_wd);
        end
        chk({v.name, "_stall_done"}, 32'(wb_stall), 32'd0);
        chk({v.name, "_req_done"}, 32'(dmem_req), 32'd0);
        chk({v.name, "_stall_cycles"}, 32'(stalls), 32'(v.waits + 1));
        @(negedge clk);
        chk({v.name, "_rf_we_pulse"}, 32'(rf_we), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"lb", 0, 3'd0, 5'd3, 32'h103, 0, 0, 32'h80FF_FF7F, 3, 1, 32'hFFFF_FF80};
        vecs[1] = '{"lhu", 0, 3'd5, 5'd4, 32'h202, 0, 0, 32'hBEEF_0000, 0, 1, 32'h0000_BEEF};
        vecs[2] = '{"lh", 0, 3'd1, 5'd4, 32'h202, 0, 0, 32'hBEEF_0000, 1, 1, 32'hFFFF_BEEF};
        vecs[3] = '{"sb", 1, 3'd0, 5'd0, 32'h301, 32'hAAAA_AAAA, 4'b0010, 0, 2, 0, 0};
        vecs[4] = '{"lw", 0, 3'd2, 5'd7, 32'h400, 0, 0, 32'h1234_5678, 0, 1, 32'h1234_5678};
        vecs[5] = '{"lbu", 0, 3'd4, 5'd8, 32'h501, 0, 0, 32'h0000_A500, 2, 1, 32'h0000_00A5};
        vecs[6] = '{"bad_op", 0, 3'd3, 5'd9, 32'h600, 0, 0, 32'hFFFF_FFFF, 0, 1, 32'h0};
        vecs[7] = '{"lw_x0", 0, 3'd2, 5'd0, 32'h700, 0, 0, 32'hCAFE_F00D, 1, 0, 0};
        vecs[8] = '{"sw", 1, 3'd2, 5'd0, 32'h804, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0};

        clear_in();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        resetb     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);
        resetb = 1'b1;

        run_alu(5'd5, 32'h1234);
        run_alu(5'd0, 32'h5555);

        for (int i = 0; i < 9; i++) run_mem(vecs[i]);

        // Ack while idle must be ignored
        @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
        chk("idle_ack_stall", 32'(wb_stall), 32'd0);
        chk("idle_ack_rf_we", 32'(rf_we), 32'd0);

        // LW to x0, then reset while busy
        @(negedge clk);
        clear_in();
        wb_mem2reg = 1'b1;
        wb_alu2reg = 1'b1;
        wb_aluop   = 3'd2;
        wb_dst_sel = 5'd0;
        wb_maddr   = 32'h900;
        wb_raddr   = 2'b00;
        @(negedge clk);
        clear_in();
        chk("rstbusy_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        chk("rstbusy_rf_we0", 32'(rf_we), 32'd0);
        resetb = 1'b0;
        @(negedge clk);
        chk("rstbusy_req_drop", 32'(dmem_req), 32'd0);
        chk("rstbusy_stall_drop", 32'(wb_stall), 32'd0);
        chk("rstbusy_rf_we1", 32'(rf_we), 32'd0);
        resetb = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("rstbusy_rf_we2", 32'(rf_we), 32'd0);
        chk("rstbusy_idle", 32'(wb_stall), 32'd0);

`ifdef MEM_WB_MISALIGN_CHK_EN
        @(negedge clk);
        clear_in();
        wb_mem2reg = 1'b1;
        wb_alu2reg = 1'b1;
        wb_aluop   = 3'd2;
        wb_dst_sel = 5'd6;
        wb_maddr   = 32'h102;
        wb_raddr   = 2'b10;
        @(negedge clk);
        clear_in();
        chk("mis_lw_err", 32'(wb_err), 32'd1);
        chk("mis_lw_req", 32'(dmem_req), 32'd0);
        chk("mis_lw_rf_we", 32'(rf_we), 32'd0);
        chk("mis_lw_stall", 32'(wb_stall), 32'd0);
        @(negedge clk);
        chk("mis_lw_err_pulse", 32'(wb_err), 32'd0);
        chk("mis_lw_req2", 32'(dmem_req), 32'd0);
        clear_in();
        wb_memwr = 1'b1;
        wb_aluop = 3'd1;
        wb_waddr = 32'h201;
        @(negedge clk);
        clear_in();
        chk("mis_sh_err", 32'(wb_err), 32'd1);
        chk("mis_sh_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk("mis_sh_err_pulse", 32'(wb_err), 32'd0);
`endif

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int k;
            logic [2:0] ops[8];
            ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
            k = $urandom_range(0, 3);
            v.name  = "rnd";
            v.dst   = 5'($urandom);
            v.addr  = $urandom;
            v.wd    = $urandom;
            v.strb  = 4'($urandom);
            v.rdat  = $urandom;
            v.waits = $urandom_range(0, 4);
            if (k == 0) begin
                run_alu(v.dst, v.wd);
            end else begin
                v.st = (k == 1);
                v.op = v.st ? 3'($urandom_range(0, 2)) : ops[$urandom_range(0, 7)];
`ifdef MEM_WB_MISALIGN_CHK_EN
                v.addr[1:0] = 2'b00;
`endif
                v.exp_we = !v.st && (v.dst != 5'd0);
                v.exp_wd = ref_load(v.op, v.addr[1:0], v.rdat);
                run_mem(v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
